bytewrite_ram_master: RTL and testbench
=======================================

Name: bytewrite_ram_master

Overview:
- Initiator-side load/store engine that drives a single-port, read-first, byte-write-enable 32-bit RAM with 1-cycle registered read data.
- Converts byte-addressed core requests (byte/half/word, signed/unsigned) into word address, byte-lane write enables and lane-replicated write data.
- Extracts and extends read data, and returns a response over a valid/ready channel.
- Sits between the nanorv32 data-side pipeline and the data RAM.

Parameters:
- ADDR_WIDTH, 12: RAM word-address width. Byte address space is 2^(ADDR_WIDTH+2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal-size request.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_we  out  4  RAM byte write enables.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid one cycle after address sampled.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0. ram_we is forced to 0 while rst_n is low.
- States:
  - IDLE: req_ready = 1.
  - RDATA: req_ready = 0.
  - RESP: resp_valid = 1, req_ready = 0.
- Accept = req_valid & req_ready.
- ram_addr and ram_din are combinational from the req_* inputs in IDLE.
  - ram_addr = req_addr[ADDR_WIDTH+1:2].
  - In RDATA, ram_addr and ram_din hold the values registered at accept.
- ram_we is nonzero only in IDLE, on an accepted, legal store. Otherwise it is 4'b0000.
- Legality:
  - size 11 is illegal.
  - half with addr[0] = 1 is misaligned.
  - word with addr[1:0] != 0 is misaligned.
  - any nonzero bit in req_addr[31:ADDR_WIDTH+2] is out of range.
  - An illegal request makes no RAM write, sets resp_err = 1, sets resp_rdata = 0, and goes IDLE -> RESP.
- Store lanes:
  - byte: ram_we = 1 << addr[1:0], ram_din = {4{wdata[7:0]}}.
  - half: ram_we = addr[1] ? 1100 : 0011, ram_din = {2{wdata[15:0]}}.
  - word: ram_we = 1111, ram_din = wdata.
- Legal store: the write commits at the accept edge; IDLE -> RESP, resp_err = 0, resp_rdata = 0.
- Legal load: IDLE -> RDATA. At the next edge, capture ram_dout, select the lane using the registered addr[1:0] and size, extend, load resp_rdata, and go RDATA -> RESP.
- Latency (accept edge = N):
  - store/error: resp_valid is high after edge N.
  - load: resp_valid is high after edge N+1.
- RESP: resp_valid, resp_rdata and resp_err stay stable until resp_valid & resp_ready. At that edge the state goes to IDLE; resp_valid drops and req_ready rises in the same cycle.
- No request is accepted in the same cycle as a response handshake. Throughput is one request per 2 cycles (store) or 3 cycles (load) with resp_ready tied high.
- resp_ready is ignored outside RESP.
- Reset mid-load (in RDATA) or mid-response (in RESP): the transaction is dropped with no response; a write already committed stays in RAM.

Test Plan:
- Word store addr 0x10, wdata 0xDEADBEEF, then word load addr 0x10 -> ram_addr 4, ram_we 1111 at accept; load resp_valid 2 cycles after accept, resp_rdata 0xDEADBEEF, resp_err 0.
- Byte store 0x80 to addr 0x13, then signed byte load 0x13 and unsigned byte load 0x13 -> ram_we 1000, ram_din 0x80808080; resp_rdata 0xFFFFFF80 then 0x00000080.
- Half store 0x1234 to addr 0x22, then signed half load 0x22 -> ram_we 1100; resp_rdata 0x00001234; word load 0x20 returns 0x1234xxxx with the low half unchanged.
- Misaligned word load 0x06, half store 0x05, size 11, and address 0x4000 (ADDR_WIDTH = 12) -> ram_we stays 0000; resp_err 1, resp_rdata 0, resp_valid after 1 cycle.
- resp_ready held low 5 cycles after a load -> resp_valid and resp_rdata stable and req_ready 0 throughout; release -> IDLE next cycle and a new request is accepted.
- rst_n pulsed low while in RDATA -> resp_valid 0 and ram_we 0 immediately; req_ready 1 after release; no stray response.

Source files
------------

// File: rtl/bytewrite_ram_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : bytewrite_ram_master                                          |
// | Description : Load/store engine for a read-first, byte-write-enable 32-bit  |
// |               RAM with one-cycle registered read data.                      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module bytewrite_ram_master #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RDATA = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_din;
    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_out_of_range;
    logic                  w_illegal;
    logic [3:0]            w_be;
    logic [31:0]           w_din;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;

    // Any address bit above the RAM's byte span flags the request out of range.
    generate
        if (ADDR_WIDTH + 2 < 32) begin : g_range_chk
            assign w_out_of_range = |req_addr[31:ADDR_WIDTH+2];
        end else begin : g_no_range_chk
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_illegal = (req_size == 2'b11)
                     | ((req_size == c_SIZE_HALF) & req_addr[0])
                     | ((req_size == c_SIZE_WORD) & (req_addr[1:0] != 2'b00))
                     | w_out_of_range;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign w_accept   = req_valid & req_ready;

    always_comb begin
        w_be  = 4'b0000;
        w_din = req_wdata;
        case (req_size)
            c_SIZE_BYTE: begin
                w_be  = 4'b0001 << req_addr[1:0];
                w_din = {4{req_wdata[7:0]}};
            end
            c_SIZE_HALF: begin
                w_be  = req_addr[1] ? 4'b1100 : 4'b0011;
                w_din = {2{req_wdata[15:0]}};
            end
            c_SIZE_WORD: w_be = 4'b1111;
            default:     w_be = 4'b0000;
        endcase
    end

    // Outside IDLE the RAM sees the request captured at accept.
    assign ram_addr = req_ready ? req_addr[ADDR_WIDTH+1:2] : r_addr;
    assign ram_din  = req_ready ? w_din : r_din;
    assign ram_we   = (w_accept & req_write & ~w_illegal & rst_n) ? w_be : 4'b0000;

    always_comb begin
        w_byte = ram_dout[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? ram_dout[31:16] : ram_dout[15:0];
        w_load = ram_dout;
        case (r_size)
            c_SIZE_BYTE: w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default:     w_load = ram_dout;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (req_write | w_illegal) ? S_RESP : S_RDATA;
                end
            end
            S_RDATA: w_state_nxt = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stores and errors respond with zero data; loads fill r_rdata in RDATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_din      <= '0;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= req_addr[ADDR_WIDTH+1:2];
                r_din      <= w_din;
                r_lane     <= req_addr[1:0];
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_rdata    <= '0;
                r_err      <= w_illegal;
            end
            if (r_state == S_RDATA) begin
                r_rdata <= w_load;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bytewrite_ram_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_bytewrite_ram_master                                       |
// | Description : Directed self-checking bench with a read-first byte-lane RAM. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_bytewrite_ram_master;

    localparam int c_AW = 12;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_rdata;
    logic            resp_err;
    logic [c_AW-1:0] ram_addr;
    logic [3:0]      ram_we;
    logic [31:0]     ram_din;
    logic [31:0]     ram_dout;

    logic [31:0]     mem [0:(1<<c_AW)-1];

    int n_checks = 0;
    int n_pass   = 0;

    bytewrite_ram_master #(.ADDR_WIDTH(c_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM: dout reflects the word before this edge's write.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [c_AW-1:0] exp_ra, input logic [3:0] exp_we,
                       input logic [31:0] exp_din, input logic [31:0] exp_rdata,
                       input logic exp_err);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; resp_ready = 1'b1;
        #1;
        chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
        chk({tag, ".ra"}, 32'(ram_addr), 32'(exp_ra));
        chk({tag, ".we"}, 32'(ram_we), 32'(exp_we));
        if (exp_we != 4'b0000) chk({tag, ".din"}, ram_din, exp_din);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!wr && !exp_err) begin
            chk({tag, ".early"}, 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk({tag, ".vld"}, 32'(resp_valid), 32'd1);
        chk({tag, ".rdata"}, resp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, ".done"}, 32'(resp_valid), 32'd0);
        chk({tag, ".idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << c_AW); i++) mem[i] = 32'h0;
        ram_dout = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld", 32'(resp_valid), 32'd0);
        chk("rst.rdata", resp_rdata, 32'h0);
        chk("rst.err", 32'(resp_err), 32'd0);
        chk("rst.we", 32'(ram_we), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rst.rdy", 32'(req_ready), 32'd1);

        //    tag     wr    sz     uns   addr          wdata         ra     we       din           rdata         err
        txn("sw10",  1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 12'h4, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0);
        txn("lw10",  1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        12'h4, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0);
        txn("sb13",  1'b1, 2'b00, 1'b0, 32'h13,       32'h80,       12'h4, 4'b1000, 32'h80808080, 32'h0,        1'b0);
        txn("lb13",  1'b0, 2'b00, 1'b0, 32'h13,       32'h0,        12'h4, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0);
        txn("lbu13", 1'b0, 2'b00, 1'b1, 32'h13,       32'h0,        12'h4, 4'b0000, 32'h0,        32'h00000080, 1'b0);
        txn("sw20",  1'b1, 2'b10, 1'b0, 32'h20,       32'hAAAA5555, 12'h8, 4'b1111, 32'hAAAA5555, 32'h0,        1'b0);
        txn("sh22",  1'b1, 2'b01, 1'b0, 32'h22,       32'h1234,     12'h8, 4'b1100, 32'h12341234, 32'h0,        1'b0);
        txn("lh22",  1'b0, 2'b01, 1'b0, 32'h22,       32'h0,        12'h8, 4'b0000, 32'h0,        32'h00001234, 1'b0);
        txn("lw20",  1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        12'h8, 4'b0000, 32'h0,        32'h12345555, 1'b0);
        txn("sh30",  1'b1, 2'b01, 1'b0, 32'h30,       32'h0000BEEF, 12'hC, 4'b0011, 32'hBEEFBEEF, 32'h0,        1'b0);
        txn("lh30",  1'b0, 2'b01, 1'b0, 32'h30,       32'h0,        12'hC, 4'b0000, 32'h0,        32'hFFFFBEEF, 1'b0);
        txn("lhu30", 1'b0, 2'b01, 1'b1, 32'h30,       32'h0,        12'hC, 4'b0000, 32'h0,        32'h0000BEEF, 1'b0);
        txn("lw06e", 1'b0, 2'b10, 1'b0, 32'h06,       32'h0,        12'h1, 4'b0000, 32'h0,        32'h0,        1'b1);
        txn("sh05e", 1'b1, 2'b01, 1'b0, 32'h05,       32'hFFFF,     12'h1, 4'b0000, 32'h0,        32'h0,        1'b1);
        txn("sz3e",  1'b1, 2'b11, 1'b0, 32'h00,       32'hFFFFFFFF, 12'h0, 4'b0000, 32'h0,        32'h0,        1'b1);
        txn("oore",  1'b0, 2'b10, 1'b0, 32'h4000,     32'h0,        12'h0, 4'b0000, 32'h0,        32'h0,        1'b1);
        txn("lw00",  1'b0, 2'b10, 1'b0, 32'h00,       32'h0,        12'h0, 4'b0000, 32'h0,        32'h0,        1'b0);

        // Back-pressure: response held while a store waits at the input.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h11111111;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall.vld", 32'(resp_valid), 32'd1);
            chk("stall.rdata", resp_rdata, 32'h80ADBEEF);
            chk("stall.rdy", 32'(req_ready), 32'd0);
            chk("stall.we", 32'(ram_we), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        chk("hs.we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        chk("hs.vld", 32'(resp_valid), 32'd0);
        chk("hs.rdy", 32'(req_ready), 32'd1);
        chk("hs.we2", 32'(ram_we), 32'hF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sw40.vld", 32'(resp_valid), 32'd1);
        chk("sw40.err", 32'(resp_err), 32'd0);
        @(posedge clk); #1;
        chk("sw40.done", 32'(resp_valid), 32'd0);
        txn("lw40",  1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        12'h10, 4'b0000, 32'h0,       32'h11111111, 1'b0);

        // Reset pulsed in RDATA drops the load; store requests during reset never write.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rdata.rdy", 32'(req_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h0;
        #1;
        chk("mid.vld", 32'(resp_valid), 32'd0);
        chk("mid.we", 32'(ram_we), 32'd0);
        chk("mid.rdata", resp_rdata, 32'h0);
        @(posedge clk); #1;
        chk("mid.we2", 32'(ram_we), 32'd0);
        req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel.rdy", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rel.vld", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        txn("lw10b", 1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        12'h4, 4'b0000, 32'h0,        32'h80ADBEEF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
